// File: rtl/smooth_filter_mc_pkg.sv
// Shared defaults and size helpers for the multi-channel moving-average smoother.
package smooth_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_CHANNELS   = 3;
  localparam int DEF_MAX_LOG2   = 4;
  localparam int DEF_SAMPLE_DIV = 250000;
  localparam int DEF_SEL_W      = 3;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  // Running-sum width: full-scale sum of a maximum window cannot overflow.
  function automatic int sum_width(input int data_w, input int max_log2);
    return data_w + max_log2;
  endfunction

  function automatic int depth_of(input int max_log2);
    return 1 << max_log2;
  endfunction

endpackage

// File: rtl/smooth_filter_mc_if.sv
// Sample/result bundle between the SPI reader, the smoother and the gesture decoder.
interface smooth_filter_mc_if
  import smooth_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = DEF_SEL_W
);

  // No valid/ready: in and win_sel are sampled level inputs, en is a one-cycle
  // strobe marking a sample capture, out_valid qualifies out after a full window.
  logic [CHANNELS*DATA_W-1:0] in;
  logic [SEL_W-1:0]           win_sel;
  logic [CHANNELS*DATA_W-1:0] out;
  logic                       en;
  logic                       out_valid;

  modport master (
    output in,
    output win_sel,
    input  out,
    input  en,
    input  out_valid
  );

  modport slave (
    input  in,
    input  win_sel,
    output out,
    output en,
    output out_valid
  );

endinterface

// File: rtl/smooth_filter_mc_ch.sv
// One channel: circular sample history, running sum and registered mean.
module smooth_filter_ch
  import smooth_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOG2 = DEF_MAX_LOG2,
  parameter int K_W      = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x,
  input  logic [MAX_LOG2-1:0]      wp,
  input  logic [K_W-1:0]           k,
  input  logic                     en,
  input  logic                     flush,
  output logic signed [DATA_W-1:0] y
);

  localparam int SUM_W  = sum_width(DATA_W, MAX_LOG2);
  localparam int DEPTH  = depth_of(MAX_LOG2);
  localparam int SPAN_W = MAX_LOG2 + 1;

  logic signed [DATA_W-1:0] hist [DEPTH];
  logic signed [SUM_W-1:0]  sum_q;
  logic signed [SUM_W-1:0]  x_ext;
  logic signed [SUM_W-1:0]  old_ext;
  logic [MAX_LOG2-1:0]      rd_idx;
  logic                     upd_q;

  // The sample leaving the window sits 2^k slots behind wp; with the largest
  // window that is the slot being overwritten.
  always_comb begin
    rd_idx  = wp - MAX_LOG2'(SPAN_W'(1) << k);
    x_ext   = $signed({{MAX_LOG2{x[DATA_W-1]}}, x});
    old_ext = $signed({{MAX_LOG2{hist[rd_idx][DATA_W-1]}}, hist[rd_idx]});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      sum_q <= '0;
      upd_q <= 1'b0;
      y     <= '0;
    end else begin
      upd_q <= en & ~flush;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        sum_q <= '0;
      end else begin
        if (en) begin
          hist[wp] <= x;
          sum_q    <= sum_q + x_ext - old_ext;
        end
        // Arithmetic shift floors toward -inf; the mean always fits DATA_W.
        if (upd_q) y <= DATA_W'(sum_q >>> k);
      end
    end
  end

endmodule

// File: rtl/smooth_filter_mc.sv
// Multi-channel moving-average smoother: prescaled sample strobe, shared
// write pointer/fill count, run-time power-of-two window with flush on change.
module smooth_filter_mc
  import smooth_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int MAX_LOG2   = DEF_MAX_LOG2,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int SEL_W      = DEF_SEL_W
) (
  input  logic               clk,
  input  logic               reset,
  smooth_filter_mc_if.slave  bus
);

  localparam int PS_W   = clog2(SAMPLE_DIV);
  localparam int K_W    = clog2(MAX_LOG2 + 1);
  localparam int FILL_W = MAX_LOG2 + 1;
  localparam int DEPTH  = depth_of(MAX_LOG2);

  logic [PS_W-1:0]            ps_cnt;
  logic                       strobe;
  logic [K_W-1:0]             k_eff;
  logic [K_W-1:0]             k_q;
  logic                       flush;
  logic [MAX_LOG2-1:0]        wp;
  logic [FILL_W-1:0]          fill;
  logic                       upd_q;
  logic                       valid_q;
  logic [CHANNELS*DATA_W-1:0] out_bus;

  // Free-running prescaler; a window flush never disturbs it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt <= '0;
    end else if (ps_cnt == PS_W'(SAMPLE_DIV - 1)) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  assign strobe = (ps_cnt == PS_W'(SAMPLE_DIV - 1));

  always_comb begin
    if (bus.win_sel > SEL_W'(MAX_LOG2)) k_eff = K_W'(MAX_LOG2);
    else                                k_eff = K_W'(bus.win_sel);
    flush = (k_eff != k_q);
  end

  // A flush takes priority over a coincident strobe, discarding that sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q     <= '0;
      wp      <= '0;
      fill    <= '0;
      upd_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      upd_q <= strobe & ~flush;
      if (flush) begin
        k_q     <= k_eff;
        fill    <= '0;
        valid_q <= 1'b0;
      end else begin
        if (strobe) begin
          wp <= wp + MAX_LOG2'(1);
          if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
        end
        if (upd_q) valid_q <= (fill >= (FILL_W'(1) << k_q));
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    smooth_filter_ch #(
      .DATA_W   (DATA_W),
      .MAX_LOG2 (MAX_LOG2),
      .K_W      (K_W)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .x     (bus.in[c*DATA_W +: DATA_W]),
      .wp    (wp),
      .k     (k_q),
      .en    (strobe),
      .flush (flush),
      .y     (out_bus[c*DATA_W +: DATA_W])
    );
  end

  assign bus.out       = out_bus;
  assign bus.en        = strobe;
  assign bus.out_valid = valid_q;

endmodule

// File: doc/smooth_filter_mc.md
Name: smooth_filter_mc

Overview:
Parametrised multi-channel moving-average smoother for signed accelerometer samples. It is the successor to the single-channel, switch-selected smooth filter.
- An internal prescaler generates the sample strobe.
- Each channel keeps a circular history and a running sum.
- Output is the arithmetic mean over a run-time selectable power-of-two window.
- Sits between the accelerometer SPI reader and the gesture/calculator decode logic.

Parameters:
DATA_W, 16, sample width per channel (two's complement)
CHANNELS, 3, number of independent axes filtered in parallel
MAX_LOG2, 4, log2 of maximum window (max window 16 samples)
SAMPLE_DIV, 250000, clock cycles between sample strobes (200 Hz at 50 MHz); must be >= 2
SEL_W, 3, width of win_sel; must satisfy 2^SEL_W > MAX_LOG2

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
in  in  CHANNELS*DATA_W  packed samples, channel c at bits [c*DATA_W +: DATA_W]
win_sel  in  SEL_W  window = 2^win_sel samples; values > MAX_LOG2 clamp to MAX_LOG2
out  out  CHANNELS*DATA_W  packed filtered means, same packing as in
en  out  1  one-cycle sample strobe
out_valid  out  1  high when the current window is completely filled since the last flush

Behaviour:
- Reset (async, active-high) clears prescaler, circular buffers, write pointer, sums, fill count, latched window, out, en and out_valid to 0.
- Prescaler counts 0..SAMPLE_DIV-1 and wraps. en=1 exactly in the cycle where count==SAMPLE_DIV-1, so the first en occurs SAMPLE_DIV cycles after reset release.
- Window latch: k_eff = min(win_sel, MAX_LOG2) is compared every cycle with the latched k. A mismatch means a flush at the next edge:
  - buffers, sums and fill count are cleared; k is latched;
  - out_valid drops to 0; out holds its last value.
- Sample cycle T (en=1, no flush pending); at the edge ending T, per channel:
  - buf[wp] <= x;
  - sum <= sum + x - buf[wp - 2^k] (index modulo 2^MAX_LOG2; unwritten entries read as 0);
  - wp increments with wrap;
  - fill <= min(fill+1, 2^MAX_LOG2).
- At the edge ending T+1:
  - out <= sum >>> k (arithmetic shift, floor toward -inf), truncated to DATA_W; the result always fits;
  - out_valid <= (fill >= 2^k).
  - Net latency: en high in T, new out visible in T+2.
- Sum width is DATA_W+MAX_LOG2 signed, so there is no overflow at full scale (16 x -32768 = -524288 fits 20 bits).
- Simultaneous flush and en: the flush wins and that sample is discarded. The prescaler is never affected by a flush.
- Before fill reaches 2^k, out still updates, computed with zero-padded history, but out_valid stays 0.
- win_sel changing back within a cycle still triggers a flush if the mismatch was present at a clock edge.
- Reset mid-window: everything returns to reset values immediately, with no partial output.
- Channels are fully independent; a single wp and fill count are shared because all channels sample on the same en.

Decomposition:
- Shared package smooth_pkg holds:
  - default DATA_W, MAX_LOG2, SAMPLE_DIV;
  - derived SUM_W = DATA_W+MAX_LOG2 and DEPTH = 2^MAX_LOG2;
  - prescaler width function clog2(SAMPLE_DIV).
- Sub-module smooth_filter_ch holds one channel's circular buffer, running sum and output register. It takes wp, k, en and flush from the top.
- Top holds the prescaler, window latch/flush detect, wp, the fill counter, and a generate loop over CHANNELS.

Test Plan:
- SAMPLE_DIV=4, reset held 200 ns then released -> en first high in cycle 4 after release, then every 4 cycles; out=0 and out_valid=0 until the first update.
- win_sel=2, channel 0 constant -500 (16'hFE0C) -> out_valid rises 2 cycles after the 4th en; out=-500.
- win_sel=2, ch0 step 0 -> 400 after a full window of 0 -> successive outputs 100, 200, 300, 400.
- win_sel=2, ch1 samples -1,0,0,0 -> out=-1 (floor).
- win_sel=4, all samples -32768 -> out=-32768.
- win_sel=5 clamps to 4.
- Window change: win_sel 0 -> 3 while running, coincident with en -> that sample discarded; out_valid=0 until 8 more ens; out held meanwhile.
- Reset asserted mid-window (between ens) -> out, out_valid and en go 0 immediately and asynchronously; after release the prescaler restarts at 0.
- Channel independence: CHANNELS=3 with inputs 100, -100, 0 -> outputs 100, -100, 0 simultaneously.
